bht_update_queue: RTL and testbench
===================================

BHT_UPDATE_QUEUE -- requirements
Module: bht_update_queue

Interface
REQ-001 SHALL have parameter CVA6Cfg, default config_pkg::cva6_cfg_empty, core configuration.
REQ-002 SHALL have parameter bht_update_t, default logic, resolved-branch update type with fields valid, pc, taken.
REQ-003 SHALL have parameter DEPTH, default 4, number of queue entries; power of two, at least 2.
REQ-004 SHALL have port clk_i, input, 1, the single clock.
REQ-005 SHALL have port rst_i, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port flush_bp_i, input, 1, branch-prediction flush.
REQ-007 SHALL have port debug_mode_i, input, 1, debug mode state from CSR.
REQ-008 SHALL have port bht_update_i, input, bht_update_t, resolved branch from EXECUTE.
REQ-009 SHALL have port upd_ready_i, input, 1, predictor accepts an update this cycle.
REQ-010 SHALL have port bht_update_o, output, bht_update_t, update to the tournament predictor.
REQ-011 SHALL have port full_o, input/output direction output, 1, queue full.
REQ-012 SHALL have port empty_o, output, 1, queue empty.
REQ-013 SHALL have port drop_cnt_o, output, 8, saturating count of dropped updates.

Function
REQ-014 SHALL enqueue when bht_update_i.valid=1, debug_mode_i=0 and flush_bp_i=0, and a slot is free or a dequeue occurs in the same cycle.
REQ-015 SHALL discard bht_update_i whenever debug_mode_i=1, without counting it as a drop.
REQ-016 SHALL treat a valid update arriving while full with upd_ready_i=0 as a drop: not stored, and drop_cnt_o incremented.
REQ-017 SHALL saturate drop_cnt_o at 8'hFF.
REQ-018 SHALL present the oldest entry on bht_update_o with valid=1 whenever the queue is not empty (FIFO order).
REQ-019 SHALL dequeue when bht_update_o.valid=1 and upd_ready_i=1.
REQ-020 SHALL hold bht_update_o stable while valid=1 and upd_ready_i=0.
REQ-021 SHALL drive bht_update_o.valid=0 with all other fields 0 when the queue is empty.
REQ-022 SHALL, with bypass disabled, make an update enqueued in cycle N visible on bht_update_o no earlier than cycle N+1.
REQ-023 SHALL use read/write pointers of log2(DEPTH)+1 bits that wrap modulo 2*DEPTH.
REQ-024 SHALL decode full as pointer MSBs differing with equal low bits, and empty as equal pointers.
REQ-025 SHALL, on simultaneous enqueue and dequeue at occupancy k, keep occupancy at k; this includes k=DEPTH.
REQ-026 SHALL, on flush_bp_i=1, set both pointers to 0 in the next cycle and discard any same-cycle input; drop_cnt_o SHALL be unchanged.
REQ-027 SHALL let flush take priority over enqueue and dequeue when they coincide.

Reset
REQ-028 SHALL, on rst_i=1 at a clk_i edge, clear both pointers and drop_cnt_o, regardless of any in-flight traffic.
REQ-029 SHALL, after reset, drive empty_o=1, full_o=0, bht_update_o.valid=0 and drop_cnt_o=0.
REQ-030 SHALL leave storage contents unreset, with no observable effect.

Configuration
REQ-031 SHALL, with BHT_UPD_QUEUE_BYPASS_EN defined, forward an eligible bht_update_i combinationally to bht_update_o in the same cycle when the queue is empty and upd_ready_i=1, without storing it.
REQ-032 SHALL, with BHT_UPD_QUEUE_BYPASS_EN undefined, have no combinational path from bht_update_i to bht_update_o.

Structure
REQ-033 SHALL place the DEPTH default and a pointer-width helper constant in ariane_pkg.
REQ-034 SHALL consist of a single module with no submodules; storage SHALL be a flop array.

Verification
REQ-035 SHALL cover: after reset, 3 enqueues at pc 0x100/0x104/0x108 with upd_ready_i=1 -> outputs 0x100, 0x104, 0x108 in order, one per cycle, starting the cycle after the first enqueue.
REQ-036 SHALL cover: 4 enqueues with upd_ready_i=0, DEPTH=4 -> full_o=1; a 5th valid update -> drop_cnt_o=1 and head still 0x100.
REQ-037 SHALL cover: full queue with simultaneous enqueue and upd_ready_i=1 -> occupancy stays 4, new entry last, drop_cnt_o unchanged.
REQ-038 SHALL cover: flush_bp_i with a valid input while holding 2 entries -> next cycle empty_o=1, valid=0, input lost.
REQ-039 SHALL cover: debug_mode_i=1 with 3 valid updates -> queue stays empty and drop_cnt_o=0.
REQ-040 SHALL cover: BHT_UPD_QUEUE_BYPASS_EN defined, empty queue, upd_ready_i=1, valid input pc 0x200 -> bht_update_o.pc=0x200 in the same cycle and empty_o stays 1.

Source files
------------

// File: rtl/ariane_pkg.sv
// Shared frontend constants and the resolved-branch update record.
package ariane_pkg;

  localparam int unsigned BHT_UPD_QUEUE_DEPTH = 4;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        taken;
  } bht_update_t;

  // One extra bit beyond the index distinguishes full from empty.
  function automatic int unsigned bht_upd_queue_ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/config_pkg.sv
// Core configuration record consumed by the branch-prediction blocks.
package config_pkg;

  typedef struct packed {
    int unsigned VLEN;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{VLEN: 32'd32};

endpackage

// File: rtl/bht_update_queue.sv
// Decouples resolved-branch updates from the tournament predictor with a small FIFO.
// Optional BHT_UPD_QUEUE_BYPASS_EN forwards an update straight through when the queue is empty.
module bht_update_queue
  import ariane_pkg::*;
#(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
  parameter type bht_update_t = ariane_pkg::bht_update_t,
  parameter int unsigned DEPTH = ariane_pkg::BHT_UPD_QUEUE_DEPTH
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_bp_i,
  input  logic        debug_mode_i,
  input  bht_update_t bht_update_i,
  input  logic        upd_ready_i,
  output bht_update_t bht_update_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [7:0]  drop_cnt_o
);

  localparam int unsigned PTR_W = bht_upd_queue_ptr_w(DEPTH);
  localparam int unsigned IDX_W = PTR_W - 1;
  localparam int unsigned PC_W  = $bits(bht_update_t) - 2;
  // PC bits above VLEN carry no architectural meaning for the predictor index.
  localparam logic [PC_W-1:0] PC_MASK = (CVA6Cfg.VLEN >= PC_W) ? {PC_W{1'b1}}
                                      : PC_W'((64'd1 << CVA6Cfg.VLEN) - 64'd1);

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  bht_update_t      mem [DEPTH];

  logic in_ok;
  logic byp;
  logic enq;
  logic deq;
  logic drop;
  logic full;
  logic empty;

  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_ptr[PTR_W-1] != wr_ptr[PTR_W-1]) &&
                 (rd_ptr[IDX_W-1:0] == wr_ptr[IDX_W-1:0]);

  assign in_ok = bht_update_i.valid && !debug_mode_i && !flush_bp_i;
  assign deq   = !empty && upd_ready_i;

`ifdef BHT_UPD_QUEUE_BYPASS_EN
  assign byp = in_ok && empty && upd_ready_i;
`else
  assign byp = 1'b0;
`endif

  // A full queue still accepts when the head leaves in the same cycle.
  assign enq  = in_ok && (!full || deq) && !byp;
  assign drop = in_ok && full && !deq;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      drop_cnt_o <= '0;
    end else if (flush_bp_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      if (drop && (drop_cnt_o != 8'hFF)) drop_cnt_o <= drop_cnt_o + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem[wr_ptr[IDX_W-1:0]] <= bht_update_i;
  end

  always_comb begin
    bht_update_o = '0;
    if (!empty) begin
      bht_update_o    = mem[rd_ptr[IDX_W-1:0]];
      bht_update_o.pc = bht_update_o.pc & PC_MASK;
    end else if (byp) begin
      bht_update_o    = bht_update_i;
      bht_update_o.pc = bht_update_i.pc & PC_MASK;
    end
  end

  assign full_o  = full;
  assign empty_o = empty;

endmodule

// File: tb/tb_bht_update_queue.sv
// Directed bench for bht_update_queue; define BHT_UPD_QUEUE_BYPASS_EN to also exercise bypass.
module tb_bht_update_queue;
  import ariane_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        flush_bp_i;
  logic        debug_mode_i;
  bht_update_t bht_update_i;
  logic        upd_ready_i;
  bht_update_t bht_update_o;
  logic        full_o;
  logic        empty_o;
  logic [7:0]  drop_cnt_o;

  int checks = 0;
  int errors = 0;

  bht_update_queue #(
    .CVA6Cfg     (config_pkg::cva6_cfg_empty),
    .bht_update_t(bht_update_t),
    .DEPTH       (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .flush_bp_i  (flush_bp_i),
    .debug_mode_i(debug_mode_i),
    .bht_update_i(bht_update_i),
    .upd_ready_i (upd_ready_i),
    .bht_update_o(bht_update_o),
    .full_o      (full_o),
    .empty_o     (empty_o),
    .drop_cnt_o  (drop_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic tk);
    bht_update_i.valid = v;
    bht_update_i.pc    = pc;
    bht_update_i.taken = tk;
  endtask

  logic [31:0] exp_pc [4];

  initial begin
    rst_i = 1'b1; flush_bp_i = 1'b0; debug_mode_i = 1'b0; upd_ready_i = 1'b0;
    drive(1'b1, 32'h0000_0bad, 1'b1);
    tick(); tick();
    rst_i = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    #1;
    chk("rst_empty", 64'(empty_o), 64'd1);
    chk("rst_full", 64'(full_o), 64'd0);
    chk("rst_valid", 64'(bht_update_o.valid), 64'd0);
    chk("rst_pc", 64'(bht_update_o.pc), 64'd0);
    chk("rst_drop", 64'(drop_cnt_o), 64'd0);

    // In-order streaming with the predictor always ready
    upd_ready_i = 1'b1;
    drive(1'b1, 32'h100, 1'b1);
    #1;
`ifndef BHT_UPD_QUEUE_BYPASS_EN
    chk("no_same_cycle", 64'(bht_update_o.valid), 64'd0);
`endif
    tick();
`ifndef BHT_UPD_QUEUE_BYPASS_EN
    drive(1'b1, 32'h104, 1'b0);
    #1;
    chk("stream0_pc", 64'(bht_update_o.pc), 64'h100);
    chk("stream0_tk", 64'(bht_update_o.taken), 64'd1);
    chk("stream0_v", 64'(bht_update_o.valid), 64'd1);
    tick();
    drive(1'b1, 32'h108, 1'b1);
    #1;
    chk("stream1_pc", 64'(bht_update_o.pc), 64'h104);
    chk("stream1_tk", 64'(bht_update_o.taken), 64'd0);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    #1;
    chk("stream2_pc", 64'(bht_update_o.pc), 64'h108);
    tick();
    #1;
    chk("stream_empty", 64'(empty_o), 64'd1);
    chk("stream_out_zero", 64'(bht_update_o), 64'd0);
`endif

    // Fill to full with predictor stalled, then overflow by one
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    upd_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0);
    #1;
    chk("fill_full", 64'(full_o), 64'd1);
    chk("fill_empty", 64'(empty_o), 64'd0);
    chk("fill_drop0", 64'(drop_cnt_o), 64'd0);
    drive(1'b1, 32'h110, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    #1;
    chk("ovf_drop", 64'(drop_cnt_o), 64'd1);
    chk("ovf_head", 64'(bht_update_o.pc), 64'h100);
    chk("ovf_hold_v", 64'(bht_update_o.valid), 64'd1);

    // Full queue: enqueue and dequeue together keep it full
    drive(1'b1, 32'h114, 1'b1);
    upd_ready_i = 1'b1;
    tick();
    drive(1'b0, 32'h0, 1'b0);
    upd_ready_i = 1'b0;
    #1;
    chk("swap_full", 64'(full_o), 64'd1);
    chk("swap_head", 64'(bht_update_o.pc), 64'h104);
    chk("swap_drop", 64'(drop_cnt_o), 64'd1);
    exp_pc[0] = 32'h104; exp_pc[1] = 32'h108; exp_pc[2] = 32'h10c; exp_pc[3] = 32'h114;
    upd_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("drain%0d", i), 64'(bht_update_o.pc), 64'(exp_pc[i]));
      tick();
    end
    #1;
    chk("drain_empty", 64'(empty_o), 64'd1);
    chk("drain_taken_last", 64'(bht_update_o.taken), 64'd0);

    // Flush with two entries held and a valid input arriving
    upd_ready_i = 1'b0;
    drive(1'b1, 32'h120, 1'b0); tick();
    drive(1'b1, 32'h124, 1'b0); tick();
    drive(1'b1, 32'h300, 1'b1);
    flush_bp_i = 1'b1;
    #1;
    chk("preflush_head", 64'(bht_update_o.pc), 64'h120);
    tick();
    flush_bp_i = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    #1;
    chk("flush_empty", 64'(empty_o), 64'd1);
    chk("flush_valid", 64'(bht_update_o.valid), 64'd0);
    chk("flush_drop", 64'(drop_cnt_o), 64'd1);
    tick();
    #1;
    chk("flush_input_lost", 64'(empty_o), 64'd1);

    // Drop counter saturation
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h400 + 32'(4 * i), 1'b0);
      tick();
    end
    drive(1'b1, 32'h500, 1'b0);
    for (int i = 0; i < 300; i++) tick();
    #1;
    chk("sat_drop", 64'(drop_cnt_o), 64'hFF);
    chk("sat_head", 64'(bht_update_o.pc), 64'h400);

    // Reset with traffic in flight
    rst_i = 1'b1;
    upd_ready_i = 1'b1;
    tick();
    rst_i = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    upd_ready_i = 1'b0;
    #1;
    chk("rst2_drop", 64'(drop_cnt_o), 64'd0);
    chk("rst2_empty", 64'(empty_o), 64'd1);
    chk("rst2_full", 64'(full_o), 64'd0);

    // Debug mode discards updates without counting drops
    debug_mode_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h600 + 32'(4 * i), 1'b1);
      tick();
    end
    debug_mode_i = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    #1;
    chk("dbg_empty", 64'(empty_o), 64'd1);
    chk("dbg_drop", 64'(drop_cnt_o), 64'd0);
    chk("dbg_valid", 64'(bht_update_o.valid), 64'd0);

`ifdef BHT_UPD_QUEUE_BYPASS_EN
    upd_ready_i = 1'b1;
    drive(1'b1, 32'h200, 1'b1);
    #1;
    chk("byp_pc", 64'(bht_update_o.pc), 64'h200);
    chk("byp_valid", 64'(bht_update_o.valid), 64'd1);
    chk("byp_empty", 64'(empty_o), 64'd1);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    #1;
    chk("byp_not_stored", 64'(empty_o), 64'd1);
    chk("byp_after_valid", 64'(bht_update_o.valid), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
